// File: rtl/rv_mem_arb.sv
// Purpose: round-robin arbiter granting one of two requesters (core, loader) a single memory port.
// Latency: x_req -> x_done is 1 + N + 1 cycles (N busy cycles incl. the ack cycle); one idle bubble between transfers.
// Backpressure: requesters hold req/fields until done; memory stalls via mem_ack, bounded by TIMEOUT (0 = wait forever).
//
// Ports:
//   clk, rst                         - clock (rising edge), asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata        - core request and its write-enable, address, write data
//   c_done/c_err/c_rdata             - core completion pulse, error flag (with done), read data (held)
//   l_*                              - loader/debug requester, same meaning as c_*
//   mem_req/mem_we/mem_addr/mem_wdata- memory request (high exactly while busy) and registered fields
//   mem_ack/mem_rdata                - memory completion and read data (valid in the ack cycle)
//   owner                            - owner of the current transfer (0 = core, 1 = loader)

module rv_mem_arb #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_done,
  output logic        c_err,
  output logic [31:0] c_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_done,
  output logic        l_err,
  output logic [31:0] l_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_C = 2'd1,
    BUSY_L = 2'd2
  } state_t;

  // Counter value seen in the last busy cycle before giving up.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_l_q;   // 1 = loader won the most recent grant
  logic             c_elig;
  logic             l_elig;
  logic             grant_c;
  logic             grant_l;
  logic             busy;
  logic             ack_hit;
  logic             to_hit;

  // A requester still showing req in its own done cycle is not a new request.
  assign c_elig  = c_req & ~c_done;
  assign l_elig  = l_req & ~l_done;
  // On a tie, the side that did not win last time gets the grant.
  assign grant_c = c_elig & (~l_elig | last_l_q);
  assign grant_l = l_elig & ~grant_c;

  assign busy    = (state_q != IDLE);
  assign ack_hit = busy & mem_ack;
  // mem_ack takes precedence over the timeout in the same cycle.
  assign to_hit  = (TIMEOUT != 0) && busy && !mem_ack && (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          state_d = BUSY_C;
        end else if (grant_l) begin
          state_d = BUSY_L;
        end
      end
      BUSY_C, BUSY_L: begin
        if (ack_hit || to_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_req = 1'b0;
    owner   = 1'b0;
    case (state_q)
      BUSY_C: mem_req = 1'b1;
      BUSY_L: begin
        mem_req = 1'b1;
        owner   = 1'b1;
      end
      default: ;
    endcase
  end

  // Timeout counter: held at zero while idle so every transfer starts from 0;
  // saturates rather than wrapping when TIMEOUT is 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!mem_ack && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Grant capture: winner's fields are registered so the bus stays stable
  // for the whole transfer regardless of what the requester does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_l_q  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if ((state_q == IDLE) && (grant_c || grant_l)) begin
      last_l_q  <= grant_l;
      mem_we    <= grant_l ? l_we    : c_we;
      mem_addr  <= grant_l ? l_addr  : c_addr;
      mem_wdata <= grant_l ? l_wdata : c_wdata;
    end
  end

  // Completion: done/err are one-cycle pulses; read data is kept until the
  // next successful read on the same port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_done  <= 1'b0;
      c_err   <= 1'b0;
      c_rdata <= '0;
      l_done  <= 1'b0;
      l_err   <= 1'b0;
      l_rdata <= '0;
    end else begin
      c_done <= 1'b0;
      c_err  <= 1'b0;
      l_done <= 1'b0;
      l_err  <= 1'b0;
      if (ack_hit || to_hit) begin
        if (owner) begin
          l_done <= 1'b1;
          l_err  <= to_hit;
          if (ack_hit && !mem_we) begin
            l_rdata <= mem_rdata;
          end
        end else begin
          c_done <= 1'b1;
          c_err  <= to_hit;
          if (ack_hit && !mem_we) begin
            c_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
module tb_rv_mem_arb;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, c_done, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        l_req, l_we, l_done, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        mem_req, mem_we, mem_ack, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errs   = 0;

  rv_mem_arb #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_done(l_done), .l_err(l_err), .l_rdata(l_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction view) ----------------
  bit          m_busy, m_who, m_last, m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_age;            // busy cycles elapsed in the current transfer
  bit   [1:0]  e_done, e_err, prev_done, elig;
  logic [31:0] e_rdata [2];

  task automatic m_reset();
    m_busy = 0; m_who = 0; m_last = 1; m_we = 0;
    m_addr = '0; m_wdata = '0; m_age = 0;
    e_done = '0; e_err = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_reset();
      end else begin
        prev_done = e_done;
        e_done = '0;
        e_err  = '0;
        if (m_busy) begin
          m_age++;
          if (mem_ack) begin
            e_done[m_who] = 1'b1;
            if (!m_we) e_rdata[m_who] = mem_rdata;
            m_busy = 0;
          end else if (TO != 0 && m_age == TO) begin
            e_done[m_who] = 1'b1;
            e_err[m_who]  = 1'b1;
            m_busy = 0;
          end
        end else begin
          elig = {l_req, c_req} & ~prev_done;
          if (elig != 2'b00) begin
            m_who   = (elig == 2'b11) ? ~m_last : elig[1];
            m_last  = m_who;
            m_busy  = 1;
            m_age   = 0;
            m_we    = m_who ? l_we    : c_we;
            m_addr  = m_who ? l_addr  : c_addr;
            m_wdata = m_who ? l_wdata : c_wdata;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("mem_req", mem_req, m_busy);
      if (m_busy || !rst) begin
        chk("owner", owner, m_who);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("c_done", c_done, e_done[0]);
      chk("l_done", l_done, e_done[1]);
      chk("c_err", c_err, e_err[0]);
      chk("l_err", l_err, e_err[1]);
      chk("c_rdata", c_rdata, e_rdata[0]);
      chk("l_rdata", l_rdata, e_rdata[1]);
      chk("done_excl", c_done & l_done, 1'b0);
    end
  end

  // ---------------- memory responder and grant monitor ----------------
  int          ack_lat = 1;      // ack in this busy cycle; 0 = never
  logic        stray_ack = 1'b0;
  int          busy_n = 0;
  int          last_len = 0;
  bit          g_own[$];
  logic        g_we[$];
  logic [31:0] g_addr[$];
  logic [31:0] g_wdata[$];

  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (busy_n == 0) begin
          g_own.push_back(owner);
          g_we.push_back(mem_we);
          g_addr.push_back(mem_addr);
          g_wdata.push_back(mem_wdata);
        end
        busy_n++;
      end else begin
        if (busy_n != 0) last_len = busy_n;
        busy_n = 0;
      end
      mem_ack = mem_req ? (ack_lat != 0 && busy_n == ack_lat) : stray_ack;
    end
  end

  task automatic clear_grants();
    g_own.delete(); g_we.delete(); g_addr.delete(); g_wdata.delete();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Issue one request and hold it until done; lat counts negedges waited.
  task automatic issue(input bit who, input bit we, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic err, output logic [31:0] rd);
    if (!who) begin
      c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d;
    end else begin
      l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(who ? l_done : c_done) && lat < 60);
    chk(who ? "l_done_seen" : "c_done_seen", who ? l_done : c_done, 1'b1);
    err = who ? l_err : c_err;
    rd  = who ? l_rdata : c_rdata;
    if (!who) c_req = 1'b0; else l_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int          lat, lat2, n;
  logic        err, err2;
  logic [31:0] rd, rd2;
  bit          exp_rr [4];

  initial begin
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    mem_rdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_l_done", l_done, 1'b0);
    @(negedge clk); #2 rst = 1'b1;

    // Core read, ack in 2nd busy cycle: done in cycle 4.
    ack_lat = 2; mem_rdata = 32'hDEADBEEF; clear_grants();
    issue(0, 0, 32'h100, 32'h0, lat, err, rd);
    chk("t1_lat", lat, 3);
    chk("t1_err", err, 1'b0);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    settle();
    chk("t1_ngrant", g_addr.size(), 1);
    if (g_addr.size() > 0) chk("t1_mem_addr", g_addr[0], 32'h100);
    chk("t1_busy_len", last_len, 2);

    // Loader read, then loader write leaves l_rdata untouched.
    ack_lat = 1; mem_rdata = 32'hCAFE0001;
    issue(1, 0, 32'h44, 32'h0, lat, err, rd);
    chk("t2_lat", lat, 2);
    chk("t2_rdata", rd, 32'hCAFE0001);
    settle();
    mem_rdata = 32'h55555555; clear_grants();
    issue(1, 1, 32'h40, 32'h12345678, lat, err, rd);
    chk("t2w_err", err, 1'b0);
    chk("t2w_rdata_kept", rd, 32'hCAFE0001);
    settle();
    chk("t2w_ngrant", g_we.size(), 1);
    if (g_we.size() > 0) begin
      chk("t2w_mem_we", g_we[0], 1'b1);
      chk("t2w_mem_wdata", g_wdata[0], 32'h12345678);
      chk("t2w_mem_addr", g_addr[0], 32'h40);
      chk("t2w_owner", g_own[0], 1'b1);
    end

    // After reset, both held: core, loader, core, loader.
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    clear_grants(); ack_lat = 1; mem_rdata = 32'h0000A000;
    fork
      begin
        issue(0, 0, 32'h200, 32'h0, lat, err, rd);
        issue(0, 1, 32'h204, 32'hC0C0, lat, err, rd);
      end
      begin
        issue(1, 0, 32'h300, 32'h0, lat2, err2, rd2);
        issue(1, 1, 32'h304, 32'h1D1D, lat2, err2, rd2);
      end
    join
    settle();
    exp_rr = '{0, 1, 0, 1};
    chk("t3_ngrant", g_own.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_own.size()) chk("t3_rr_order", g_own[i], exp_rr[i]);
    end

    // Core wins alone, then a tie must go to the loader.
    clear_grants();
    issue(0, 0, 32'h210, 32'h0, lat, err, rd);
    fork
      issue(0, 0, 32'h214, 32'h0, lat, err, rd);
      issue(1, 0, 32'h314, 32'h0, lat2, err2, rd2);
    join
    settle();
    chk("t4_ngrant", g_own.size(), 3);
    if (g_own.size() > 1) chk("t4_tie_loader", g_own[1], 1'b1);
    chk("t4_l_lat", lat2, 2);
    chk("t4_c_lat", lat, 4);

    // No ack: mem_req for exactly TO cycles, then done with error.
    ack_lat = 0; mem_rdata = 32'h77777777;
    issue(0, 0, 32'h500, 32'h0, lat, err, rd);
    chk("t5_err", err, 1'b1);
    chk("t5_lat", lat, 5);
    chk("t5_rdata_kept", rd, 32'h0000A000);
    settle();
    chk("t5_busy_len", last_len, 4);

    // Ack in the last allowed busy cycle beats the timeout.
    ack_lat = 4; mem_rdata = 32'h0BADF00D;
    issue(0, 0, 32'h504, 32'h0, lat, err, rd);
    chk("t6_err", err, 1'b0);
    chk("t6_lat", lat, 5);
    chk("t6_rdata", rd, 32'h0BADF00D);
    settle();
    chk("t6_busy_len", last_len, 4);

    // Stray ack while idle is ignored.
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t7_mem_req", mem_req, 1'b0);
    chk("t7_c_done", c_done, 1'b0);
    chk("t7_c_rdata", c_rdata, 32'h0BADF00D);
    stray_ack = 1'b0;
    settle();

    // Reset during BUSY_L: mem_req drops without an edge, no l_done.
    ack_lat = 0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h80; l_wdata = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && owner) && n < 10);
    chk("t8_busy_l", mem_req & owner, 1'b1);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("t8_mem_req_async", mem_req, 1'b0);
    chk("t8_no_l_done", l_done, 1'b0);
    l_req = 1'b0;
    @(negedge clk);
    #1 chk("t8_no_l_done2", l_done, 1'b0);
    @(negedge clk); #2 rst = 1'b1;
    clear_grants(); ack_lat = 1;
    fork
      issue(0, 0, 32'h600, 32'h0, lat, err, rd);
      issue(1, 0, 32'h700, 32'h0, lat2, err2, rd2);
    join
    settle();
    chk("t8_ngrant", g_own.size(), 2);
    if (g_own.size() > 0) chk("t8_tie_core", g_own[0], 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
